// File: rtl/fp_sum_sq_acc.sv
// rtl/fp_sum_sq_acc.sv - streaming sum-of-squares accumulator feeding the inverse-square-root stage
module fp_sum_sq_acc #(
  parameter int VEC_LEN = 3,
  parameter int CNT_W   = 4
) (
  input  logic        clk,
  input  logic        rst,
  input  logic [31:0] in_data,
  input  logic        in_valid,
  output logic        in_ready,
  output logic [31:0] out_data,
  output logic        out_valid,
  input  logic        out_ready,
  output logic        out_zero,
  output logic        out_special
);

  typedef enum logic [2:0] {S_IDLE, S_MUL, S_ADD, S_WB, S_OUT} state_t;

  localparam logic [CNT_W-1:0] LAST = CNT_W'(VEC_LEN - 1);

  state_t           state_q, state_d;
  logic [31:0]      op_q, op_d;
  logic [31:0]      sq_q, sq_d;
  logic [31:0]      sum_q, sum_d;
  logic [31:0]      acc_q, acc_d;
  logic [CNT_W-1:0] count_q, count_d;
  logic             special_q, special_d;

  // Single-precision multiply, denormals flushed to zero, round to nearest even.
  function automatic logic [31:0] fp_mul(input logic [31:0] a, input logic [31:0] b);
    logic               s;
    logic [7:0]         ea, eb;
    logic               a_nan, b_nan, a_inf, b_inf, a_zero, b_zero;
    logic [47:0]        p;
    logic signed [9:0]  e;
    logic [22:0]        m;
    logic               g, st;
    logic [30:0]        r;
    logic [31:0]        res;
    s      = a[31] ^ b[31];
    ea     = a[30:23];
    eb     = b[30:23];
    a_nan  = (ea == 8'hFF) && (a[22:0] != 23'd0);
    b_nan  = (eb == 8'hFF) && (b[22:0] != 23'd0);
    a_inf  = (ea == 8'hFF) && (a[22:0] == 23'd0);
    b_inf  = (eb == 8'hFF) && (b[22:0] == 23'd0);
    a_zero = (ea == 8'd0);
    b_zero = (eb == 8'd0);
    p = {24'd0, 1'b1, a[22:0]} * {24'd0, 1'b1, b[22:0]};
    e = $signed({2'b00, ea}) + $signed({2'b00, eb}) - 10'sd127;
    if (p[47]) begin
      m  = p[46:24];
      g  = p[23];
      st = |p[22:0];
      e  = e + 10'sd1;
    end else begin
      m  = p[45:23];
      g  = p[22];
      st = |p[21:0];
    end
    // A rounding carry out of the mantissa ripples into the exponent, reaching Inf cleanly.
    r = {e[7:0], m} + {30'd0, g & (st | m[0])};
    if (a_nan || b_nan || (a_inf && b_zero) || (b_inf && a_zero)) res = 32'h7FC00000;
    else if (a_inf || b_inf)                                      res = {s, 8'hFF, 23'd0};
    else if (a_zero || b_zero)                                    res = {s, 31'd0};
    else if (e >= 10'sd255)                                       res = {s, 8'hFF, 23'd0};
    else if (e <= 10'sd0)                                         res = {s, 31'd0};
    else                                                          res = {s, r};
    return res;
  endfunction

  // Magnitude add: both operands are squares, so only non-negative values (or NaN) arrive.
  function automatic logic [30:0] fp_add(input logic [30:0] x, input logic [30:0] y);
    logic [30:0] a, b;
    logic [7:0]  ea, eb, d, er;
    logic [23:0] ma, mb;
    logic [24:0] s;
    logic [22:0] mr;
    logic [30:0] res;
    if (y > x) begin a = y; b = x; end
    else       begin a = x; b = y; end
    ea = a[30:23];
    eb = b[30:23];
    d  = ea - eb;
    ma = {1'b1, a[22:0]};
    mb = {1'b1, b[22:0]} >> d;
    s  = {1'b0, ma} + {1'b0, mb};
    if (s[24]) begin er = ea + 8'd1; mr = s[23:1]; end
    else       begin er = ea;        mr = s[22:0]; end
    if (ea == 8'hFF)      res = (a[22:0] != 23'd0) ? 31'h7FC00000 : 31'h7F800000;
    else if (eb == 8'd0)  res = a;
    else if (er == 8'hFF) res = 31'h7F800000;
    else                  res = {er, mr};
    return res;
  endfunction

  // Next-state and datapath: multiplier and adder see only registered operands.
  always_comb begin
    state_d   = state_q;
    op_d      = op_q;
    sq_d      = sq_q;
    sum_d     = sum_q;
    acc_d     = acc_q;
    count_d   = count_q;
    special_d = special_q;
    case (state_q)
      S_IDLE: begin
        if (in_valid) begin
          op_d      = in_data;
          special_d = special_q | (in_data[30:23] == 8'hFF);
          state_d   = S_MUL;
        end
      end
      S_MUL: begin
        sq_d    = fp_mul(op_q, op_q);
        state_d = S_ADD;
      end
      S_ADD: begin
        sum_d   = {1'b0, fp_add(acc_q[30:0], sq_q[30:0])};
        state_d = S_WB;
      end
      S_WB: begin
        acc_d = (count_q == '0) ? sq_q : sum_q;
        if (count_q == LAST) begin
          state_d = S_OUT;
        end else begin
          count_d = count_q + CNT_W'(1);
          state_d = S_IDLE;
        end
      end
      S_OUT: begin
        if (out_ready) begin
          acc_d     = 32'd0;
          count_d   = '0;
          special_d = 1'b0;
          state_d   = S_IDLE;
        end
      end
      default: state_d = S_IDLE;
    endcase
  end

  // State registers; reset discards any partial vector.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q   <= S_IDLE;
      op_q      <= 32'd0;
      sq_q      <= 32'd0;
      sum_q     <= 32'd0;
      acc_q     <= 32'd0;
      count_q   <= '0;
      special_q <= 1'b0;
    end else begin
      state_q   <= state_d;
      op_q      <= op_d;
      sq_q      <= sq_d;
      sum_q     <= sum_d;
      acc_q     <= acc_d;
      count_q   <= count_d;
      special_q <= special_d;
    end
  end

  assign in_ready    = (state_q == S_IDLE);
  assign out_valid   = (state_q == S_OUT);
  assign out_data    = acc_q;
  assign out_zero    = out_valid & (acc_q[30:23] == 8'd0);
  assign out_special = out_valid & (special_q | (acc_q[30:23] == 8'hFF));

endmodule
